// File: rtl/pwm_multi_ch.sv
// Multi-channel PWM generator with a shared prescaled counter (edge- or center-aligned)
// and per-channel double-buffered duty registers that update only at period boundaries.
module pwm_multi_ch #(
    parameter int WIDTH    = 8,
    parameter int CHANNELS = 4,
    parameter int PRESC_W  = 8
) (
    input  logic                        clk,
    input  logic                        resetn,
    input  logic                        enable,
    input  logic                        mode,
    input  logic [PRESC_W-1:0]          prescale,
    input  logic [WIDTH-1:0]            period,
    input  logic                        wr_en,
    input  logic [$clog2(CHANNELS)-1:0] wr_ch,
    input  logic [WIDTH-1:0]            wr_duty,
    output logic [CHANNELS-1:0]         pwm_out,
    output logic                        period_start,
    output logic [WIDTH-1:0]            count
);

    localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

    typedef enum logic {DIR_UP = 1'b0, DIR_DOWN = 1'b1} dir_t;

    logic [PRESC_W-1:0] presc_cnt;
    logic [PRESC_W-1:0] prescale_a;
    logic [WIDTH-1:0]   period_a;
    logic               mode_a;
    logic [WIDTH-1:0]   cnt;
    dir_t               dir;
    logic [WIDTH-1:0]   pending [CHANNELS];
    logic [WIDTH-1:0]   active  [CHANNELS];

    logic               tick;
    logic               wrap;
    logic               boundary;
    logic               reload;
    logic [WIDTH-1:0]   cnt_next;
    dir_t               dir_next;

    assign tick     = enable && (presc_cnt == prescale_a);
    assign boundary = tick && wrap;
    assign reload   = !enable || boundary;

    // Next counter value for a tick; wrap marks the tick that ends a period.
    always_comb begin
        cnt_next = cnt;
        dir_next = dir;
        wrap     = 1'b0;
        if (!mode_a) begin
            dir_next = DIR_UP;
            if (cnt >= period_a) begin
                cnt_next = '0;
                wrap     = 1'b1;
            end else begin
                cnt_next = cnt + ONE;
            end
        end else if (period_a == '0) begin
            cnt_next = '0;
            dir_next = DIR_UP;
            wrap     = 1'b1;
        end else if (dir == DIR_UP) begin
            if (cnt >= period_a) begin
                cnt_next = cnt - ONE;
                dir_next = DIR_DOWN;
            end else begin
                cnt_next = cnt + ONE;
            end
        end else begin
            if (cnt <= ONE) begin
                cnt_next = '0;
                dir_next = DIR_UP;
                wrap     = 1'b1;
            end else begin
                cnt_next = cnt - ONE;
            end
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            presc_cnt    <= '0;
            prescale_a   <= '0;
            period_a     <= '0;
            mode_a       <= 1'b0;
            cnt          <= '0;
            dir          <= DIR_UP;
            period_start <= 1'b0;
        end else begin
            period_start <= boundary;
            if (!enable) begin
                presc_cnt <= '0;
                cnt       <= '0;
                dir       <= DIR_UP;
            end else begin
                presc_cnt <= tick ? '0 : presc_cnt + 1'b1;
                if (tick) begin
                    cnt <= cnt_next;
                    dir <= dir_next;
                end
            end
            // Timing settings only change where a new period begins, so a period never mixes them.
            if (reload) begin
                prescale_a <= prescale;
                period_a   <= period;
                mode_a     <= mode;
            end
        end
    end

    // A write landing on a reload cycle passes straight through to the active copy.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            for (int i = 0; i < CHANNELS; i++) begin
                pending[i] <= '0;
                active[i]  <= '0;
            end
        end else begin
            for (int i = 0; i < CHANNELS; i++) begin
                if (wr_en && (int'(wr_ch) == i)) begin
                    pending[i] <= wr_duty;
                end
                if (reload) begin
                    active[i] <= (wr_en && (int'(wr_ch) == i)) ? wr_duty : pending[i];
                end
            end
        end
    end

    always_comb begin
        pwm_out = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            pwm_out[i] = enable && (cnt < active[i]);
        end
    end

    assign count = enable ? cnt : '0;

endmodule

// File: tb/tb_pwm_multi_ch.sv
// Scoreboard bench for pwm_multi_ch: stimulus queues the expected outputs of each cycle,
// a negedge monitor pops and compares them against the DUT.
module tb_pwm_multi_ch;

    localparam int WIDTH    = 8;
    localparam int CHANNELS = 3;
    localparam int PRESC_W  = 8;

    logic                  clk = 1'b0;
    logic                  resetn;
    logic                  enable;
    logic                  mode;
    logic [PRESC_W-1:0]    prescale;
    logic [WIDTH-1:0]      period;
    logic                  wr_en;
    logic [1:0]            wr_ch;
    logic [WIDTH-1:0]      wr_duty;
    logic [CHANNELS-1:0]   pwm_out;
    logic                  period_start;
    logic [WIDTH-1:0]      count;

    logic [11:0] exp_q  [$];
    string       name_q [$];
    int          n_checks = 0;
    int          n_pass   = 0;

    pwm_multi_ch #(.WIDTH(WIDTH), .CHANNELS(CHANNELS), .PRESC_W(PRESC_W)) dut (
        .clk          (clk),
        .resetn       (resetn),
        .enable       (enable),
        .mode         (mode),
        .prescale     (prescale),
        .period       (period),
        .wr_en        (wr_en),
        .wr_ch        (wr_ch),
        .wr_duty      (wr_duty),
        .pwm_out      (pwm_out),
        .period_start (period_start),
        .count        (count)
    );

    always #5 clk = ~clk;

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic check_output(input string nm, input logic [2:0] p, input logic [7:0] c, input logic s);
        exp_q.push_back({p, c, s});
        name_q.push_back(nm);
    endtask

    task automatic apply_stimulus(input logic we, input logic [1:0] ch, input logic [7:0] d);
        wr_en   = we;
        wr_ch   = ch;
        wr_duty = d;
    endtask

    always @(negedge clk) begin
        while (exp_q.size() > 0) begin
            logic [11:0] e;
            string       nm;
            e  = exp_q.pop_front();
            nm = name_q.pop_front();
            n_checks++;
            if ({pwm_out, count, period_start} === e)
                n_pass++;
            else
                $display("[TB] FAIL %s: got pwm=%b count=%0d ps=%b, want pwm=%b count=%0d ps=%b",
                         nm, pwm_out, count, period_start, e[11:9], e[8:1], e[0]);
        end
    end

    initial begin
        logic [7:0] c;
        logic [7:0] seq [8];
        seq = '{8'd0, 8'd1, 8'd2, 8'd3, 8'd4, 8'd3, 8'd2, 8'd1};

        resetn = 1'b0; enable = 1'b0; mode = 1'b0; prescale = '0; period = '0;
        apply_stimulus(1'b0, 2'd0, 8'd0);
        next_cycle();
        check_output("reset", 3'b000, 8'd0, 1'b0);
        next_cycle();

        // Edge mode, period 9, prescale 0; ch0=3, ch1=2 loaded while disabled.
        resetn = 1'b1; period = 8'd9;
        apply_stimulus(1'b1, 2'd0, 8'd3);
        next_cycle();
        apply_stimulus(1'b1, 2'd1, 8'd2);
        next_cycle();
        apply_stimulus(1'b0, 2'd0, 8'd0);
        enable = 1'b1;
        for (int k = 0; k < 65; k++) begin
            if (k == 24)      apply_stimulus(1'b1, 2'd1, 8'd7);
            else if (k == 39) apply_stimulus(1'b1, 2'd0, 8'd5);
            else if (k == 42) apply_stimulus(1'b1, 2'd3, 8'd9);
            else              apply_stimulus(1'b0, 2'd0, 8'd0);
            c = 8'(k % 10);
            check_output("edge", {1'b0, c < ((k < 30) ? 8'd2 : 8'd7), c < ((k < 40) ? 8'd3 : 8'd5)},
                         c, (k > 0) && (c == 8'd0));
            next_cycle();
        end

        // Drop enable mid-period (count 5), write ch2 while disabled, then restart.
        enable = 1'b0;
        apply_stimulus(1'b1, 2'd2, 8'd4);
        check_output("dis_same", 3'b000, 8'd0, 1'b0);
        next_cycle();
        apply_stimulus(1'b0, 2'd0, 8'd0);
        check_output("dis_hold", 3'b000, 8'd0, 1'b0);
        next_cycle();
        enable = 1'b1;
        for (int j = 0; j < 12; j++) begin
            c = 8'(j % 10);
            check_output("reenable", {c < 8'd4, c < 8'd7, c < 8'd5}, c, j == 10);
            next_cycle();
        end

        // Duty 255 with period 9 is always high.
        enable = 1'b0;
        apply_stimulus(1'b1, 2'd2, 8'd255);
        next_cycle();
        apply_stimulus(1'b0, 2'd0, 8'd0);
        enable = 1'b1;
        for (int j = 0; j < 12; j++) begin
            c = 8'(j % 10);
            check_output("duty_full", {1'b1, c < 8'd7, c < 8'd5}, c, j == 10);
            next_cycle();
        end

        // Full-range period: count runs to 255 and wraps to 0.
        enable = 1'b0;
        period = 8'd255;
        next_cycle();
        enable = 1'b1;
        for (int j = 0; j < 260; j++) begin
            c = 8'(j);
            check_output("wrap255", {c < 8'd255, c < 8'd7, c < 8'd5}, c, j == 256);
            next_cycle();
        end

        // Center mode, period 4, prescale 1, ch0=2; switch to edge/9/0 mid-period.
        enable = 1'b0;
        mode = 1'b1; period = 8'd4; prescale = 8'd1;
        apply_stimulus(1'b1, 2'd0, 8'd2);
        next_cycle();
        apply_stimulus(1'b0, 2'd0, 8'd0);
        enable = 1'b1;
        for (int j = 0; j < 48; j++) begin
            if (j == 20) begin
                mode = 1'b0; period = 8'd9; prescale = 8'd0;
            end
            if (j < 32) begin
                c = seq[(j / 2) % 8];
                check_output("center", {1'b1, c < 8'd7, c < 8'd2}, c, j == 16);
            end else begin
                c = 8'((j - 32) % 10);
                check_output("mode_switch", {1'b1, c < 8'd7, c < 8'd2}, c, c == 8'd0);
            end
            next_cycle();
        end

        // Asynchronous reset between clock edges (count is 6 here, outputs active).
        resetn = 1'b0;
        check_output("async_rst", 3'b000, 8'd0, 1'b0);
        next_cycle();
        enable = 1'b0;
        resetn = 1'b1;
        next_cycle();
        enable = 1'b1;
        check_output("post_rst", 3'b000, 8'd0, 1'b0);
        next_cycle();

        @(negedge clk);
        #1;
        n_checks++;
        if (exp_q.size() == 0)
            n_pass++;
        else
            $display("[TB] FAIL drain: got %0d queued, want 0", exp_q.size());
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
